// File: rtl/exc_unit_if.sv
// Port bundle between the MEM-stage pipeline/CP0 (master) and exc_unit (slave).
// Inputs are sampled when valid_m && !stall_m in IDLE; there is no backpressure from exc_unit.
interface exc_unit_if #(
   parameter int unsigned NUM_HW_INT = 6
);

   logic                  stall_m;
   logic                  valid_m;
   logic [31:0]           pc_m;
   logic                  bd_m;
   logic [7:0]            except_m;
   logic                  adel;
   logic                  ades;
   logic [31:0]           mem_addr;
   logic [NUM_HW_INT-1:0] hw_int;
   logic [1:0]            sw_ip;
   logic [7:0]            status_im;
   logic                  status_ie;
   logic                  epc_wr_en;
   logic [31:0]           epc_wr_data;
   logic                  exl_wr_en;
   logic                  exl_wr_data;

   logic                  flush;
   logic [31:0]           newpc;
   logic [4:0]            exc_code;
   logic                  eret_taken;
   logic [31:0]           epc;
   logic [31:0]           badvaddr;
   logic                  cause_bd;
   logic [7:0]            cause_ip;
   logic                  exl;
   logic [0:0]            state_dbg;

   modport master (
      output stall_m, valid_m, pc_m, bd_m, except_m, adel, ades, mem_addr,
             hw_int, sw_ip, status_im, status_ie,
             epc_wr_en, epc_wr_data, exl_wr_en, exl_wr_data,
      input  flush, newpc, exc_code, eret_taken, epc, badvaddr, cause_bd,
             cause_ip, exl, state_dbg
   );

   modport slave (
      input  stall_m, valid_m, pc_m, bd_m, except_m, adel, ades, mem_addr,
             hw_int, sw_ip, status_im, status_ie,
             epc_wr_en, epc_wr_data, exl_wr_en, exl_wr_data,
      output flush, newpc, exc_code, eret_taken, epc, badvaddr, cause_bd,
             cause_ip, exl, state_dbg
   );

endinterface

// File: rtl/exc_unit.sv
// Registered exception/ERET prioritiser at the end of MEM: commits one event,
// then holds a single-cycle flush with the redirect PC. Owns EXL, EPC, BadVAddr, Cause.
module exc_unit #(
   parameter int unsigned NUM_HW_INT  = 6,
   parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic       clk,
   input logic       resetn,
   exc_unit_if.slave bus
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0A;
   localparam logic [4:0] EXC_OV   = 5'h0C;

   logic [0:0]  state;
   logic [SYNC_STAGES-1:0][NUM_HW_INT-1:0] sync_q;
   logic [NUM_HW_INT-1:0] hw_sync;
   logic [5:0]  hw_ext;
   logic [7:0]  cause_ip;
   logic        int_pend;
   logic        detect;

   logic [31:0] newpc_q;
   logic [4:0]  exc_code_q;
   logic        eret_taken_q;
   logic [31:0] epc_q;
   logic [31:0] badvaddr_q;
   logic        cause_bd_q;
   logic        exl_q;

   logic        exc_hit;
   logic        eret_hit;
   logic [4:0]  hit_code;
   logic        badv_load;
   logic [31:0] badv_val;

   logic        pc_err;
   logic        unused_rsvd;

   assign pc_err      = bus.except_m[7];
   assign unused_rsvd = ^bus.except_m[1:0];

   // hw_int is asynchronous; only the last stage of the chain is ever observed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.hw_int};
      end
   end

   assign hw_sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      hw_ext = '0;
      hw_ext[NUM_HW_INT-1:0] = hw_sync;
   end

   assign cause_ip = {hw_ext, bus.sw_ip};
   assign int_pend = (|(cause_ip & bus.status_im)) & bus.status_ie & ~exl_q;
   assign detect   = (state == S_IDLE) & bus.valid_m & ~bus.stall_m;

   always_comb begin
      exc_hit   = 1'b0;
      eret_hit  = 1'b0;
      hit_code  = EXC_INT;
      badv_load = 1'b0;
      badv_val  = bus.mem_addr;
      if (detect) begin
         if (int_pend) begin
            exc_hit  = 1'b1;
            hit_code = EXC_INT;
         end else if (pc_err || bus.adel) begin
            exc_hit   = 1'b1;
            hit_code  = EXC_ADEL;
            badv_load = 1'b1;
            badv_val  = pc_err ? bus.pc_m : bus.mem_addr;
         end else if (bus.ades) begin
            exc_hit   = 1'b1;
            hit_code  = EXC_ADES;
            badv_load = 1'b1;
         end else if (bus.except_m[6]) begin
            exc_hit  = 1'b1;
            hit_code = EXC_SYS;
         end else if (bus.except_m[5]) begin
            exc_hit  = 1'b1;
            hit_code = EXC_BP;
         end else if (bus.except_m[4]) begin
            eret_hit = 1'b1;
         end else if (bus.except_m[3]) begin
            exc_hit  = 1'b1;
            hit_code = EXC_RI;
         end else if (bus.except_m[2]) begin
            exc_hit  = 1'b1;
            hit_code = EXC_OV;
         end
      end
   end

   // The commit wins only over the fields it actually writes; an ERET
   // therefore still lets a same-cycle MTC0 land in EPC.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= S_IDLE;
         newpc_q      <= '0;
         exc_code_q   <= '0;
         eret_taken_q <= 1'b0;
         epc_q        <= '0;
         badvaddr_q   <= '0;
         cause_bd_q   <= 1'b0;
         exl_q        <= 1'b1;
      end else begin
         state <= (exc_hit || eret_hit) ? S_FLUSH : S_IDLE;

         if (exc_hit && !exl_q) begin
            epc_q      <= bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
            cause_bd_q <= bus.bd_m;
         end else if (bus.epc_wr_en) begin
            epc_q <= bus.epc_wr_data;
         end

         if (exc_hit) begin
            newpc_q      <= EXC_VECTOR;
            exc_code_q   <= hit_code;
            eret_taken_q <= 1'b0;
            exl_q        <= 1'b1;
         end else if (eret_hit) begin
            newpc_q      <= bus.epc_wr_en ? bus.epc_wr_data : epc_q;
            eret_taken_q <= 1'b1;
            exl_q        <= 1'b0;
         end else if (bus.exl_wr_en) begin
            exl_q <= bus.exl_wr_data;
         end

         if (badv_load) begin
            badvaddr_q <= badv_val;
         end
      end
   end

   assign bus.flush      = (state == S_FLUSH);
   assign bus.newpc      = newpc_q;
   assign bus.exc_code   = exc_code_q;
   assign bus.eret_taken = eret_taken_q;
   assign bus.epc        = epc_q;
   assign bus.badvaddr   = badvaddr_q;
   assign bus.cause_bd   = cause_bd_q;
   assign bus.cause_ip   = cause_ip;
   assign bus.exl        = exl_q;
   assign bus.state_dbg  = state;

endmodule

// File: tb/tb_exc_unit.sv
// Bench for exc_unit: directed scenarios followed by random traffic, all checked
// against a cycle-level reference model built from the exception rules.
module tb_exc_unit;

   localparam int unsigned NHW    = 6;
   localparam int unsigned SYNC_N = 2;
   localparam logic [31:0] VEC    = 32'hBFC00380;

   logic clk;
   logic resetn;
   int   n_chk;
   int   n_pass;

   exc_unit_if #(.NUM_HW_INT(NHW)) bus ();

   exc_unit #(
      .NUM_HW_INT (NHW),
      .EXC_VECTOR (VEC),
      .SYNC_STAGES(SYNC_N)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic        m_flush;
   logic [31:0] m_newpc;
   logic [4:0]  m_code;
   logic        m_eret;
   logic [31:0] m_epc;
   logic [31:0] m_badv;
   logic        m_bd;
   logic        m_exl;
   logic [NHW-1:0] sync_hist[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_flush = 1'b0; m_newpc = '0; m_code = '0; m_eret = 1'b0;
      m_epc = '0; m_badv = '0; m_bd = 1'b0; m_exl = 1'b1;
      sync_hist = {};
      repeat (SYNC_N) sync_hist.push_back('0);
   endtask

   // Advance the model by one clock edge using the inputs currently on the bus.
   task automatic model_edge();
      logic [7:0]  cip;
      logic        pend;
      logic        det;
      logic        hits[8];
      int          codes[8];
      int          sel;
      logic        old_exl;
      logic [31:0] old_epc;
      cip     = {2'b00, 6'(sync_hist[0]), bus.sw_ip};
      pend    = (|(cip & bus.status_im)) && bus.status_ie && !m_exl;
      det     = !m_flush && bus.valid_m && !bus.stall_m;
      hits    = '{pend, bus.except_m[7] | bus.adel, bus.ades, bus.except_m[6],
                  bus.except_m[5], bus.except_m[4], bus.except_m[3], bus.except_m[2]};
      codes   = '{0, 4, 5, 8, 9, -1, 10, 12};
      old_exl = m_exl;
      old_epc = m_epc;
      sel     = -1;
      if (det) for (int i = 0; i < 8; i++) if (hits[i] && sel < 0) sel = i;

      if (bus.epc_wr_en) m_epc = bus.epc_wr_data;
      if (bus.exl_wr_en) m_exl = bus.exl_wr_data;
      m_flush = (sel >= 0);
      if (sel == 5) begin
         m_newpc = bus.epc_wr_en ? bus.epc_wr_data : old_epc;
         m_eret  = 1'b1;
         m_exl   = 1'b0;
      end else if (sel >= 0) begin
         m_newpc = VEC;
         m_code  = 5'(codes[sel]);
         m_eret  = 1'b0;
         m_exl   = 1'b1;
         if (!old_exl) begin
            m_epc = bus.bd_m ? bus.pc_m - 32'd4 : bus.pc_m;
            m_bd  = bus.bd_m;
         end
         if (sel == 1) m_badv = bus.except_m[7] ? bus.pc_m : bus.mem_addr;
         if (sel == 2) m_badv = bus.mem_addr;
      end
      sync_hist.push_back(bus.hw_int);
      void'(sync_hist.pop_front());
   endtask

   task automatic check_outputs();
      check("flush", 32'(bus.flush), 32'(m_flush));
      if (m_flush) check("newpc", bus.newpc, m_newpc);
      check("exc_code", 32'(bus.exc_code), 32'(m_code));
      check("eret_taken", 32'(bus.eret_taken), 32'(m_eret));
      check("epc", bus.epc, m_epc);
      check("badvaddr", bus.badvaddr, m_badv);
      check("cause_bd", 32'(bus.cause_bd), 32'(m_bd));
      check("exl", 32'(bus.exl), 32'(m_exl));
      check("cause_ip", 32'(bus.cause_ip), 32'({2'b00, 6'(sync_hist[0]), bus.sw_ip}));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic clear_inputs();
      bus.stall_m = 1'b0; bus.valid_m = 1'b0; bus.pc_m = '0; bus.bd_m = 1'b0;
      bus.except_m = '0; bus.adel = 1'b0; bus.ades = 1'b0; bus.mem_addr = '0;
      bus.epc_wr_en = 1'b0; bus.epc_wr_data = '0;
      bus.exl_wr_en = 1'b0; bus.exl_wr_data = 1'b0;
   endtask

   // Called just after a rising edge; reset is held across one edge.
   task automatic do_reset();
      resetn = 1'b0;
      #1;
      model_reset();
      check("rst_flush", 32'(bus.flush), 32'd0);
      check("rst_exl", 32'(bus.exl), 32'd1);
      check("rst_newpc", bus.newpc, 32'd0);
      check_outputs();
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic set_exl(input logic v);
      clear_inputs();
      bus.exl_wr_en = 1'b1;
      bus.exl_wr_data = v;
      step();
      clear_inputs();
   endtask

   initial begin
      logic [7:0] e;
      n_chk = 0;
      n_pass = 0;
      resetn = 1'b0;
      clear_inputs();
      bus.hw_int = '0; bus.sw_ip = '0; bus.status_im = '0; bus.status_ie = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Syscall outside a delay slot
      set_exl(1'b0);
      bus.valid_m = 1'b1; bus.pc_m = 32'hBFC00100; bus.except_m = 8'h40;
      step();
      check("t1_flush", 32'(bus.flush), 32'd1);
      check("t1_newpc", bus.newpc, 32'hBFC00380);
      check("t1_code", 32'(bus.exc_code), 32'h08);
      check("t1_epc", bus.epc, 32'hBFC00100);
      clear_inputs();
      step();
      check("t1_flush_len", 32'(bus.flush), 32'd0);

      // pcError AdEL in a delay slot
      set_exl(1'b0);
      bus.valid_m = 1'b1; bus.pc_m = 32'hBFC00204; bus.bd_m = 1'b1;
      bus.except_m = 8'h80; bus.adel = 1'b1; bus.mem_addr = 32'h1003;
      step();
      check("t2_code", 32'(bus.exc_code), 32'h04);
      check("t2_badv", bus.badvaddr, 32'hBFC00204);
      check("t2_epc", bus.epc, 32'hBFC00200);
      check("t2_bd", 32'(bus.cause_bd), 32'd1);
      clear_inputs();
      step();

      // Interrupt beats a simultaneous overflow; nothing before the sync delay
      set_exl(1'b0);
      bus.status_im = 8'h04; bus.status_ie = 1'b1; bus.hw_int = 6'b000001;
      bus.valid_m = 1'b1; bus.pc_m = 32'h200;
      for (int i = 0; i < SYNC_N; i++) begin
         step();
         check("t3_no_early", 32'(bus.flush), 32'd0);
      end
      bus.except_m = 8'h04;
      step();
      check("t3_code", 32'(bus.exc_code), 32'h00);
      check("t3_flush", 32'(bus.flush), 32'd1);
      clear_inputs();
      bus.status_ie = 1'b0; bus.hw_int = '0;
      step();

      // ERET with EPC forwarded from a same-cycle MTC0
      bus.epc_wr_en = 1'b1; bus.epc_wr_data = 32'h100;
      step();
      clear_inputs();
      bus.valid_m = 1'b1; bus.except_m = 8'h10;
      bus.epc_wr_en = 1'b1; bus.epc_wr_data = 32'hBFC00500;
      step();
      check("t4_newpc", bus.newpc, 32'hBFC00500);
      check("t4_eret", 32'(bus.eret_taken), 32'd1);
      check("t4_exl", 32'(bus.exl), 32'd0);
      clear_inputs();
      step();

      // Nested breakpoint keeps EPC; exception during FLUSH is dropped
      set_exl(1'b1);
      bus.valid_m = 1'b1; bus.pc_m = 32'h40; bus.except_m = 8'h20;
      step();
      check("t5_code", 32'(bus.exc_code), 32'h09);
      check("t5_epc", bus.epc, 32'hBFC00500);
      bus.pc_m = 32'h44; bus.except_m = 8'h40;
      step();
      check("t5_squash", 32'(bus.flush), 32'd0);
      check("t5_code_hold", 32'(bus.exc_code), 32'h09);
      clear_inputs();
      step();

      // Stalled syscall, then reset in the middle of FLUSH
      set_exl(1'b0);
      bus.valid_m = 1'b1; bus.stall_m = 1'b1; bus.pc_m = 32'h80; bus.except_m = 8'h40;
      repeat (3) begin
         step();
         check("t6_stalled", 32'(bus.flush), 32'd0);
      end
      bus.stall_m = 1'b0;
      step();
      check("t6_flush", 32'(bus.flush), 32'd1);
      clear_inputs();
      do_reset();
      step();
      check("t6_after_rst", 32'(bus.flush), 32'd0);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         bus.valid_m  = ($urandom_range(0, 3) != 0);
         bus.stall_m  = ($urandom_range(0, 4) == 0);
         bus.pc_m     = $urandom;
         bus.bd_m     = 1'($urandom_range(0, 1));
         e = '0;
         for (int b = 2; b < 8; b++) e[b] = ($urandom_range(0, 7) == 0);
         e[1:0] = 2'($urandom_range(0, 3));
         bus.except_m = e;
         bus.adel     = ($urandom_range(0, 9) == 0);
         bus.ades     = ($urandom_range(0, 9) == 0);
         bus.mem_addr = $urandom;
         if ($urandom_range(0, 19) == 0) bus.hw_int = NHW'($urandom);
         if ($urandom_range(0, 29) == 0) bus.sw_ip = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) bus.status_im = 8'($urandom);
         if ($urandom_range(0, 29) == 0) bus.status_ie = 1'($urandom_range(0, 1));
         bus.epc_wr_en   = ($urandom_range(0, 7) == 0);
         bus.epc_wr_data = $urandom;
         bus.exl_wr_en   = ($urandom_range(0, 5) == 0);
         bus.exl_wr_data = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 399) == 0) do_reset();
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
